arm_banked_regfile: RTL and testbench

Parametrised ARM register file that replaces the flat 37-entry bank with mode-resolved banking, a configurable number of read ports, masked CPSR/SPSR access and a built-in exception-entry sequencer. Sits between decode/execute and the fetch PC. It resolves architectural R0–R15 to physical registers from CPSR[4:0] and performs the SPSR/LR/CPSR/PC updates of exception entry as an atomic multi-cycle sequence.

---
 rtl/arm_banked_regfile.sv | 194 +++++++++++++++++++
 tb/tb_arm_banked_regfile.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_banked_regfile.sv
// ARM register file with CPSR-mode banking, NUM_RD combinational read ports,
// masked CPSR/SPSR access and an atomic exception-entry sequencer.
module arm_banked_regfile #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NUM_RD   = 3,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] VEC_BASE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [4*NUM_RD-1:0]      rd_addr,
  output logic [DATA_W*NUM_RD-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [3:0]               wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pc_inc,
  input  logic                     pc_we,
  input  logic [DATA_W-1:0]        pc_wdata,
  output logic [DATA_W-1:0]        pc_out,
  input  logic                     cpsr_we,
  input  logic [31:0]              cpsr_wdata,
  input  logic [31:0]              cpsr_mask,
  output logic [31:0]              cpsr_out,
  input  logic                     spsr_we,
  input  logic [31:0]              spsr_wdata,
  output logic [31:0]              spsr_out,
  input  logic                     exc_req,
  input  logic [2:0]               exc_type,
  input  logic [DATA_W-1:0]        exc_ret_addr,
  output logic                     exc_busy,
  output logic                     exc_done
);

  typedef enum logic [1:0] {IDLE, SAVE, SWITCH, DONE} state_t;

  localparam logic [31:0]       CPSR_RST = 32'h0000_00D3;
  localparam logic [DATA_W-1:0] PC_FOUR  = DATA_W'(4);
  localparam logic [DATA_W-1:0] PC_EIGHT = DATA_W'(8);

  // Bank index: 0 usr/sys (and unknown encodings), 1 fiq, 2 irq, 3 svc, 4 abt, 5 und
  function automatic logic [2:0] bank_of(input logic [4:0] m);
    case (m)
      5'b10001: bank_of = 3'd1;
      5'b10010: bank_of = 3'd2;
      5'b10011: bank_of = 3'd3;
      5'b10111: bank_of = 3'd4;
      5'b11011: bank_of = 3'd5;
      default:  bank_of = 3'd0;
    endcase
  endfunction

  function automatic logic [4:0] mode_of_type(input logic [2:0] t);
    case (t)
      3'd1:       mode_of_type = 5'b11011;
      3'd3, 3'd4: mode_of_type = 5'b10111;
      3'd6:       mode_of_type = 5'b10010;
      3'd7:       mode_of_type = 5'b10001;
      default:    mode_of_type = 5'b10011;
    endcase
  endfunction

  logic [DATA_W-1:0] r_low    [0:7];
  logic [DATA_W-1:0] r_hi_usr [8:12];
  logic [DATA_W-1:0] r_hi_fiq [8:12];
  logic [DATA_W-1:0] r13      [0:5];
  logic [DATA_W-1:0] r14      [0:5];
  logic [31:0]       spsr     [0:5];
  logic [DATA_W-1:0] pc_q;
  logic [31:0]       cpsr_q;
  logic [2:0]        type_q;
  logic [DATA_W-1:0] ret_q;
  logic              done_q;
  state_t            state_q, state_d;

  logic              busy;
  logic              exc_accept;
  logic [2:0]        cur_bank;
  logic              cur_fiq;
  logic [4:0]        tgt_mode;
  logic [2:0]        tgt_bank;
  logic              tgt_f;
  logic [DATA_W-1:0] vec_pc;
  logic [3:0]        ra;

  assign busy       = (state_q != IDLE);
  assign exc_accept = (state_q == IDLE) && exc_req && (exc_type != 3'd5);
  assign cur_bank   = bank_of(cpsr_q[4:0]);
  assign cur_fiq    = (cur_bank == 3'd1);
  assign tgt_mode   = mode_of_type(type_q);
  assign tgt_bank   = bank_of(tgt_mode);
  assign tgt_f      = (type_q == 3'd0) || (type_q == 3'd7) || cpsr_q[6];
  // Vector offsets are exactly exc_type * 4
  assign vec_pc     = VEC_BASE + {{(DATA_W-5){1'b0}}, type_q, 2'b00};

  assign pc_out   = pc_q;
  assign cpsr_out = cpsr_q;
  assign spsr_out = (cur_bank == 3'd0) ? 32'h0 : spsr[cur_bank];
  assign exc_busy = busy;
  assign exc_done = done_q;

  always_comb begin
    rd_data = '0;
    ra      = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = rd_addr[4*k +: 4];
      case (ra)
        4'd13:   rd_data[DATA_W*k +: DATA_W] = r13[cur_bank];
        4'd14:   rd_data[DATA_W*k +: DATA_W] = r14[cur_bank];
        4'd15:   rd_data[DATA_W*k +: DATA_W] = pc_q + PC_EIGHT;
        default: begin
          if (ra < 4'd8)
            rd_data[DATA_W*k +: DATA_W] = r_low[ra[2:0]];
          else if (cur_fiq)
            rd_data[DATA_W*k +: DATA_W] = r_hi_fiq[ra];
          else
            rd_data[DATA_W*k +: DATA_W] = r_hi_usr[ra];
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (exc_accept) state_d = SAVE;
      SAVE:    state_d = SWITCH;
      SWITCH:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_d == DONE);
    end
  end

  // Writes use the bank selected by the CPSR value present before the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_low[i] <= '0;
      for (int i = 8; i < 13; i++) begin
        r_hi_usr[i] <= '0;
        r_hi_fiq[i] <= '0;
      end
      for (int i = 0; i < 6; i++) begin
        r13[i]  <= '0;
        r14[i]  <= '0;
        spsr[i] <= '0;
      end
      pc_q   <= RESET_PC;
      cpsr_q <= CPSR_RST;
      type_q <= '0;
      ret_q  <= '0;
    end else begin
      if (!busy) begin
        if (wr_en) begin
          case (wr_addr)
            4'd13:   r13[cur_bank] <= wr_data;
            4'd14:   r14[cur_bank] <= wr_data;
            4'd15:   ;
            default: begin
              if (wr_addr < 4'd8)  r_low[wr_addr[2:0]] <= wr_data;
              else if (cur_fiq)    r_hi_fiq[wr_addr]   <= wr_data;
              else                 r_hi_usr[wr_addr]   <= wr_data;
            end
          endcase
        end
        if (spsr_we && (cur_bank != 3'd0)) spsr[cur_bank] <= spsr_wdata;
        if (cpsr_we) cpsr_q <= (cpsr_q & ~cpsr_mask) | (cpsr_wdata & cpsr_mask);
        if (pc_we)                          pc_q <= pc_wdata;
        else if (wr_en && wr_addr == 4'd15) pc_q <= wr_data;
        else if (pc_inc)                    pc_q <= pc_q + PC_FOUR;
      end
      if (exc_accept) begin
        type_q <= exc_type;
        ret_q  <= exc_ret_addr;
      end
      if (state_q == SAVE) begin
        spsr[tgt_bank] <= cpsr_q;
        r14[tgt_bank]  <= ret_q;
      end
      if (state_q == SWITCH) begin
        cpsr_q <= {cpsr_q[31:8], 1'b1, tgt_f, 1'b0, tgt_mode};
        pc_q   <= vec_pc;
      end
    end
  end

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Directed bench for arm_banked_regfile: reset, banking, PC priority, exception entry, abort.
module tb_arm_banked_regfile;

  logic        clk;
  logic        rst_n;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_inc;
  logic        pc_we;
  logic [31:0] pc_wdata;
  logic [31:0] pc_out;
  logic        cpsr_we;
  logic [31:0] cpsr_wdata;
  logic [31:0] cpsr_mask;
  logic [31:0] cpsr_out;
  logic        spsr_we;
  logic [31:0] spsr_wdata;
  logic [31:0] spsr_out;
  logic        exc_req;
  logic [2:0]  exc_type;
  logic [31:0] exc_ret_addr;
  logic        exc_busy;
  logic        exc_done;

  arm_banked_regfile #(
    .DATA_W(32), .NUM_RD(3), .RESET_PC(32'h0), .VEC_BASE(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pc_inc(pc_inc), .pc_we(pc_we), .pc_wdata(pc_wdata), .pc_out(pc_out),
    .cpsr_we(cpsr_we), .cpsr_wdata(cpsr_wdata), .cpsr_mask(cpsr_mask), .cpsr_out(cpsr_out),
    .spsr_we(spsr_we), .spsr_wdata(spsr_wdata), .spsr_out(spsr_out),
    .exc_req(exc_req), .exc_type(exc_type), .exc_ret_addr(exc_ret_addr),
    .exc_busy(exc_busy), .exc_done(exc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpsr_we;
    logic [31:0] cpsr_wdata;
    logic [31:0] cpsr_mask;
    logic        spsr_we;
    logic [31:0] spsr_wdata;
    logic        pc_inc;
    logic        pc_we;
    logic [31:0] pc_wdata;
    logic [3:0]  ra;
    logic [31:0] exp_rd;
    logic [31:0] exp_cpsr;
    logic [31:0] exp_pc;
    logic [31:0] exp_spsr;
  } vec_t;

  vec_t vecs [0:20];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pc_inc = 1'b0; pc_we = 1'b0; pc_wdata = '0;
    cpsr_we = 1'b0; cpsr_wdata = '0; cpsr_mask = '0;
    spsr_we = 1'b0; spsr_wdata = '0;
    exc_req = 1'b0; exc_type = '0; exc_ret_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    // wr_en addr data | cpsr_we wdata mask | spsr_we wdata | pc_inc pc_we pc_wdata | ra exp_rd exp_cpsr exp_pc exp_spsr
    vecs[0]  = '{1'b1, 4'd13, 32'h1111, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd13, 32'h1111, 32'hD3, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h10, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd13, 32'h0,    32'hD0, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 4'd13, 32'h2222, 1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd13, 32'h2222, 32'hD0, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h13, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd13, 32'h1111, 32'hD3, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 4'd14, 32'h3333, 1'b1, 32'h10, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd14, 32'h0,    32'hD0, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h13, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd14, 32'h3333, 32'hD3, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 4'd0,  32'h0,    1'b0, 32'h0,  32'h0,  1'b1, 32'hABCD, 1'b0, 1'b0, 32'h0, 4'd14, 32'h3333, 32'hD3, 32'h0, 32'hABCD};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h10, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd8,  32'h0,    32'hD0, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 4'd8,  32'hA,    1'b0, 32'h0,  32'h0,  1'b1, 32'h5555, 1'b0, 1'b0, 32'h0, 4'd8,  32'hA,    32'hD0, 32'h0, 32'h0};
    vecs[9]  = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h11, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd8,  32'h0,    32'hD1, 32'h0, 32'h0};
    vecs[10] = '{1'b1, 4'd8,  32'hB,    1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd8,  32'hB,    32'hD1, 32'h0, 32'h0};
    vecs[11] = '{1'b1, 4'd3,  32'h77,   1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd3,  32'h77,   32'hD1, 32'h0, 32'h0};
    vecs[12] = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h10, 32'h1F, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd8,  32'hA,    32'hD0, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 4'd0,  32'h0,    1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h0, 4'd3,  32'h77,   32'hD0, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 4'd0,  32'h0,    1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h0, 4'd15, 32'hC,    32'hD0, 32'h4, 32'h0};
    vecs[15] = '{1'b1, 4'd15, 32'h800,  1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b1, 1'b1, 32'h400, 4'd15, 32'h408, 32'hD0, 32'h400, 32'h0};
    vecs[16] = '{1'b1, 4'd15, 32'h800,  1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h0, 4'd15, 32'h808,  32'hD0, 32'h800, 32'h0};
    vecs[17] = '{1'b0, 4'd0,  32'h0,    1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b0, 1'b1, 32'hFFFFFFFC, 4'd15, 32'h4, 32'hD0, 32'hFFFFFFFC, 32'h0};
    vecs[18] = '{1'b0, 4'd0,  32'h0,    1'b0, 32'h0,  32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h0, 4'd15, 32'h8,    32'hD0, 32'h0, 32'h0};
    vecs[19] = '{1'b0, 4'd0,  32'h0,    1'b1, 32'hA0000000, 32'hF0000000, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd0, 32'h0, 32'hA00000D0, 32'h0, 32'h0};
    vecs[20] = '{1'b0, 4'd0,  32'h0,    1'b1, 32'h10, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'd14, 32'h0, 32'h10, 32'h0, 32'h0};

    clear_inputs();
    rst_n   = 1'b0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset state
    for (int i = 0; i < 15; i++) begin
      rd_addr = {4'(i), 4'(i), 4'(i)};
      #1;
      check($sformatf("reset_r%0d_p0", i), rd_data[31:0], 32'h0);
      check($sformatf("reset_r%0d_p2", i), rd_data[95:64], 32'h0);
    end
    rd_addr = {4'd15, 4'd15, 4'd15};
    #1;
    check("reset_r15", rd_data[63:32], 32'h8);
    check("reset_cpsr", cpsr_out, 32'hD3);
    check("reset_pc", pc_out, 32'h0);
    check("reset_spsr", spsr_out, 32'h0);
    check("reset_busy", {31'h0, exc_busy}, 32'h0);
    check("reset_done", {31'h0, exc_done}, 32'h0);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 21; i++) begin
      wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      cpsr_we = vecs[i].cpsr_we; cpsr_wdata = vecs[i].cpsr_wdata; cpsr_mask = vecs[i].cpsr_mask;
      spsr_we = vecs[i].spsr_we; spsr_wdata = vecs[i].spsr_wdata;
      pc_inc = vecs[i].pc_inc; pc_we = vecs[i].pc_we; pc_wdata = vecs[i].pc_wdata;
      rd_addr = {4'd15, 4'd0, vecs[i].ra};
      tick();
      clear_inputs();
      check($sformatf("vec%0d_rd", i), rd_data[31:0], vecs[i].exp_rd);
      check($sformatf("vec%0d_cpsr", i), cpsr_out, vecs[i].exp_cpsr);
      check($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
      check($sformatf("vec%0d_r15", i), rd_data[95:64], vecs[i].exp_pc + 32'h8);
      check($sformatf("vec%0d_spsr", i), spsr_out, vecs[i].exp_spsr);
    end

    // IRQ entry from usr; R0 write on the accepting edge still lands
    exc_req = 1'b1; exc_type = 3'd6; exc_ret_addr = 32'h104;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h55;
    rd_addr = {4'd15, 4'd13, 4'd14};
    tick();
    exc_req = 1'b1; exc_type = 3'd1; exc_ret_addr = 32'h999;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'h99;
    pc_inc = 1'b1; pc_we = 1'b0;
    cpsr_we = 1'b1; cpsr_wdata = 32'h20000000; cpsr_mask = 32'h20000000;
    spsr_we = 1'b1; spsr_wdata = 32'hDEAD;
    check("irq_n0_busy", {31'h0, exc_busy}, 32'h1);
    check("irq_n0_done", {31'h0, exc_done}, 32'h0);
    tick();
    check("irq_n1_busy", {31'h0, exc_busy}, 32'h1);
    check("irq_n1_done", {31'h0, exc_done}, 32'h0);
    check("irq_n1_cpsr", cpsr_out, 32'h10);
    check("irq_n1_pc", pc_out, 32'h0);
    check("irq_n1_usr_lr", rd_data[31:0], 32'h0);
    tick();
    check("irq_n2_busy", {31'h0, exc_busy}, 32'h1);
    check("irq_n2_done", {31'h0, exc_done}, 32'h1);
    check("irq_n2_cpsr", cpsr_out, 32'h92);
    check("irq_n2_pc", pc_out, 32'h18);
    check("irq_n2_spsr", spsr_out, 32'h10);
    check("irq_n2_lr", rd_data[31:0], 32'h104);
    tick();
    clear_inputs();
    check("irq_n3_busy", {31'h0, exc_busy}, 32'h0);
    check("irq_n3_done", {31'h0, exc_done}, 32'h0);
    check("irq_n3_cpsr", cpsr_out, 32'h92);
    check("irq_n3_pc", pc_out, 32'h18);
    check("irq_n3_spsr", spsr_out, 32'h10);
    rd_addr = {4'd15, 4'd1, 4'd0};
    #1;
    check("irq_r0_accept_edge", rd_data[31:0], 32'h55);
    check("irq_r1_busy_write", rd_data[63:32], 32'h0);
    tick();
    check("irq_idle_done", {31'h0, exc_done}, 32'h0);
    check("irq_idle_busy", {31'h0, exc_busy}, 32'h0);

    // Reserved exception type is ignored
    exc_req = 1'b1; exc_type = 3'd5; exc_ret_addr = 32'h300;
    tick();
    clear_inputs();
    check("rsvd_busy", {31'h0, exc_busy}, 32'h0);
    tick();
    check("rsvd_done", {31'h0, exc_done}, 32'h0);
    check("rsvd_cpsr", cpsr_out, 32'h92);

    // FIQ request aborted by reset before SAVE
    exc_req = 1'b1; exc_type = 3'd7; exc_ret_addr = 32'h200;
    tick();
    clear_inputs();
    check("abort_busy_pre", {31'h0, exc_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, exc_busy}, 32'h0);
    check("abort_done", {31'h0, exc_done}, 32'h0);
    check("abort_cpsr", cpsr_out, 32'hD3);
    check("abort_pc", pc_out, 32'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("abort_busy_post", {31'h0, exc_busy}, 32'h0);
    cpsr_we = 1'b1; cpsr_wdata = 32'h11; cpsr_mask = 32'h1F;
    rd_addr = {4'd15, 4'd0, 4'd14};
    tick();
    clear_inputs();
    check("abort_fiq_cpsr", cpsr_out, 32'hD1);
    check("abort_fiq_lr", rd_data[31:0], 32'h0);
    check("abort_fiq_spsr", spsr_out, 32'h0);
    check("abort_r0", rd_data[63:32], 32'h0);
    check("abort_r15", rd_data[95:64], 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
